// File: rtl/fifo_2b_valid_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fifo_2b_valid_pkg                                             |
// | Purpose  : Shared defaults for the 2-bit valid-stream datapath (mux,     |
// |            FIFO and later stages): default word width, default depth   |
// |            and the reset-active level.                                   |
// | Ports    : none (package)                                                |
// | Options  : none                                                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`ifndef FIFO_2B_VALID_PKG_SV
`define FIFO_2B_VALID_PKG_SV

package fifo_2b_valid_pkg;

  localparam int   DEF_DATA_W = 2;
  localparam int   DEF_DEPTH  = 4;
  // Reset is active-low throughout this datapath.
  localparam logic RST_ACTIVE = 1'b0;

endpackage

`endif
`default_nettype wire

// File: rtl/fifo_mem_2b.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fifo_mem_2b                                                   |
// | Purpose  : DEPTH x DATA_W register array with a synchronous write port  |
// |            and a registered, enable-gated read port.                     |
// | Ports    : clk, reset (sync, active-low, clears read register only),    |
// |            wr_en/wr_addr/wr_data, rd_en/rd_addr, rd_data (registered).  |
// | Options  : none                                                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module fifo_mem_2b
  import fifo_2b_valid_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is intentionally not reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // A same-edge write to rd_addr is not forwarded: the old word is read.
  always_ff @(posedge clk) begin
    if (reset == RST_ACTIVE) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_2b_valid.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fifo_2b_valid                                                 |
// | Purpose  : Small synchronous FIFO behind the 2-bit mux-with-valid stage. |
// |            Captures valid words, holds them until popped, and reports   |
// |            occupancy flags plus overflow/underflow errors.              |
// | Ports    : clk, reset (sync, active-low), in_data/in_valid (push),      |
// |            pop, out_data/out_valid (one cycle after accepted pop),      |
// |            full, empty, almost_full, almost_empty, count,               |
// |            overflow_err, underflow_err.                                  |
// | Options  : FIFO_ERR_STICKY_EN - errors hold until reset; otherwise      |
// |            each error is a single-cycle pulse.                           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module fifo_2b_valid
  import fifo_2b_valid_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = 2,
  parameter int AF_THR = 3,
  parameter int AE_THR = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              pop,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow_err,
  output logic              underflow_err
);

  localparam logic [ADDR_W:0] DEPTH_LVL = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] AF_LVL    = AF_THR[ADDR_W:0];
  localparam logic [ADDR_W:0] AE_LVL    = AE_THR[ADDR_W:0];

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              pop_acc;
  logic              push_acc;
  logic              push_drop;
  logic              pop_bad;

  // Flags decode straight from the registered count.
  assign full         = (count == DEPTH_LVL);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_LVL);
  assign almost_empty = (count <= AE_LVL);

  assign pop_acc   = pop && !empty;
  // When full, a push is still taken if a pop frees a slot on the same edge.
  assign push_acc  = in_valid && (!full || pop_acc);
  assign push_drop = in_valid && !push_acc;
  assign pop_bad   = pop && empty;

  fifo_mem_2b #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push_acc),
    .wr_addr (wr_ptr),
    .wr_data (in_data),
    .rd_en   (pop_acc),
    .rd_addr (rd_ptr),
    .rd_data (out_data)
  );

  always_ff @(posedge clk) begin
    if (reset == RST_ACTIVE) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      out_valid     <= 1'b0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      // Pointers wrap naturally since DEPTH == 2**ADDR_W.
      if (push_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop_acc)  rd_ptr <= rd_ptr + 1'b1;

      if (push_acc && !pop_acc) begin
        count <= count + 1'b1;
      end else if (pop_acc && !push_acc) begin
        count <= count - 1'b1;
      end

      out_valid <= pop_acc;

`ifdef FIFO_ERR_STICKY_EN
      overflow_err  <= overflow_err  | push_drop;
      underflow_err <= underflow_err | pop_bad;
`else
      overflow_err  <= push_drop;
      underflow_err <= pop_bad;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_2b_valid.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fifo_2b_valid                                              |
// | Purpose  : Directed self-checking bench for fifo_2b_valid: reset, fill, |
// |            overflow, drain order, underflow, full push+pop, empty       |
// |            push+pop, mid-stream reset and error persistence.            |
// | Options  : FIFO_ERR_STICKY_EN selects sticky-error expectations.        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_fifo_2b_valid;

  logic       clk;
  logic       reset;
  logic [1:0] in_data;
  logic       in_valid;
  logic       pop;
  logic [1:0] out_data;
  logic       out_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [2:0] count;
  logic       overflow_err;
  logic       underflow_err;

  int checks   = 0;
  int failures = 0;

`ifdef FIFO_ERR_STICKY_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  fifo_2b_valid dut (
    .clk           (clk),
    .reset         (reset),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .pop           (pop),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .full          (full),
    .empty         (empty),
    .almost_full   (almost_full),
    .almost_empty  (almost_empty),
    .count         (count),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Apply inputs, take one rising edge, settle just past it.
  task automatic step(input logic v, input logic [1:0] d, input logic p);
    in_valid = v;
    in_data  = d;
    pop      = p;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 2'b00;
    pop      = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [1:0] exp_q [4];

    // 1. Reset release
    do_reset(2);
    check("rst_empty", empty, 1);
    check("rst_aempty", almost_empty, 1);
    check("rst_full", full, 0);
    check("rst_afull", almost_full, 0);
    check("rst_count", count, 0);
    check("rst_ovalid", out_valid, 0);
    check("rst_odata", out_data, 0);
    check("rst_ovf", overflow_err, 0);
    check("rst_unf", underflow_err, 0);

    // 2. Fill and overflow
    step(1, 2'b01, 0);
    check("fill1_count", count, 1);
    check("fill1_aempty", almost_empty, 1);
    step(1, 2'b10, 0);
    check("fill2_count", count, 2);
    check("fill2_aempty", almost_empty, 0);
    check("fill2_afull", almost_full, 0);
    step(1, 2'b11, 0);
    check("fill3_count", count, 3);
    check("fill3_afull", almost_full, 1);
    check("fill3_full", full, 0);
    step(1, 2'b00, 0);
    check("fill4_count", count, 4);
    check("fill4_full", full, 1);
    step(1, 2'b11, 0);
    check("ovf_set", overflow_err, 1);
    check("ovf_count", count, 4);
    step(0, 2'b00, 0);
    check("ovf_after", overflow_err, STICKY);

    // 3. Drain order then underflow
    exp_q = '{2'b01, 2'b10, 2'b11, 2'b00};
    for (int i = 0; i < 4; i++) begin
      step(0, 2'b00, 1);
      check($sformatf("drain%0d_valid", i), out_valid, 1);
      check($sformatf("drain%0d_data", i), out_data, exp_q[i]);
    end
    check("drain_empty", empty, 1);
    check("drain_count", count, 0);
    step(0, 2'b00, 1);
    check("unf_set", underflow_err, 1);
    check("unf_valid", out_valid, 0);
    check("unf_hold", out_data, 2'b00);
    check("unf_ovf_state", overflow_err, STICKY);

    do_reset(1);
    check("rst2_ovf", overflow_err, 0);
    check("rst2_unf", underflow_err, 0);

    // 4. Full with simultaneous push and pop, across pointer wrap
    for (int i = 0; i < 4; i++) step(1, 2'(i), 0);
    check("full4_full", full, 1);
    step(1, 2'b10, 1);
    check("fpp_valid", out_valid, 1);
    check("fpp_data", out_data, 2'b00);
    check("fpp_count", count, 4);
    check("fpp_ovf", overflow_err, 0);
    exp_q = '{2'b01, 2'b10, 2'b11, 2'b10};
    for (int i = 0; i < 4; i++) begin
      step(0, 2'b00, 1);
      check($sformatf("fpp_pop%0d", i), out_data, exp_q[i]);
    end
    check("fpp_end_count", count, 0);

    // 5. Push and pop on empty
    step(1, 2'b11, 1);
    check("epp_valid", out_valid, 0);
    check("epp_unf", underflow_err, 1);
    check("epp_count", count, 1);
    step(0, 2'b00, 1);
    check("epp_pop_valid", out_valid, 1);
    check("epp_pop_data", out_data, 2'b11);
    check("epp_unf_after", underflow_err, STICKY);

    // 6. Reset mid-stream
    step(1, 2'b10, 0);
    step(1, 2'b10, 0);
    step(1, 2'b10, 0);
    check("mid_count", count, 3);
    check("mid_unf_state", underflow_err, STICKY);
    do_reset(1);
    check("mid_rst_count", count, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_unf", underflow_err, 0);
    check("mid_rst_ovf", overflow_err, 0);
    step(1, 2'b01, 0);
    step(0, 2'b00, 1);
    check("post_rst_data", out_data, 2'b01);
    check("post_rst_valid", out_valid, 1);
    check("post_rst_empty", empty, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_2b_valid.md
Name: fifo_2b_valid

Overview:
- Small synchronous FIFO placed directly downstream of the 2-bit mux-with-valid stage.
- Captures each valid 2-bit word from the mux output and holds it until the consumer pops it.
- Decouples the mux's cycle-by-cycle valid stream from a consumer that may stall.
- Reports occupancy flags and overflow/underflow errors.

Parameters:
- DATA_W, 2, width of a stored word.
- DEPTH, 4, number of entries; must be a power of 2, minimum 2.
- ADDR_W, 2, pointer width; equals log2(DEPTH).
- AF_THR, 3, almost_full asserts when count >= AF_THR.
- AE_THR, 1, almost_empty asserts when count <= AE_THR.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous reset, active-low.
- in_data  input  DATA_W  write data; connects to the mux out_b.
- in_valid  input  1  push request; connects to the mux out_valid_b.
- pop  input  1  read request from the consumer.
- out_data  output  DATA_W  registered read data.
- out_valid  output  1  high for exactly one cycle after an accepted pop.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_THR.
- almost_empty  output  1  count <= AE_THR.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow_err  output  1  a push was dropped.
- underflow_err  output  1  a pop was issued while empty.

Behaviour:
- Clock is clk. Reset is reset: synchronous, active-low. Reset is sampled only on the rising edge of clk.
- While reset==0:
  - wr_ptr, rd_ptr and count are 0.
  - out_data=0, out_valid=0, overflow_err=0, underflow_err=0.
  - empty=1, almost_empty=1, full=0, almost_full=0.
  - Memory contents are not cleared.
- Push accepted: in_valid && (!full || pop_acc).
  - On accept: mem[wr_ptr] <= in_data; wr_ptr <= wr_ptr+1, wrapping modulo DEPTH.
- Pop accepted (pop_acc): pop && !empty.
  - On accept: out_data <= mem[rd_ptr]; out_valid <= 1; rd_ptr <= rd_ptr+1, wrapping modulo DEPTH.
  - Otherwise: out_valid <= 0 and out_data holds its last value.
- Read latency: out_data/out_valid are valid in the cycle after the edge on which pop was sampled.
- Minimum write-to-read latency:
  - A word pushed at edge N can be popped at edge N+1 at the earliest.
  - It then appears on out_data after edge N+1.
  - There is no same-cycle bypass.
- count update:
  - +1 on push only; -1 on pop only.
  - Unchanged when push and pop are both accepted, or when neither is.
- Flags are combinational decodes of the registered count; there is no extra latency.
- Full plus simultaneous in_valid and pop: both are accepted, count stays DEPTH, and the oldest word is read out.
- Full with in_valid and no pop: the word is dropped; pointers and count are unchanged; overflow_err is set.
- Empty with pop (with or without in_valid):
  - The pop is not accepted and out_valid=0.
  - underflow_err is set.
  - A simultaneous push is still accepted and count becomes 1.
- Pointer wrap: after DEPTH pushes, wr_ptr returns to 0. Ordering across the wrap is strict FIFO.
- Reset mid-operation: all contents are discarded logically. The first pop after reset release reads only data pushed after release.

Optional Feature:
- Macro: FIFO_ERR_STICKY_EN.
- Defined: overflow_err and underflow_err are sticky. Once set, they stay 1 until reset==0.
- Undefined: each error is a single-cycle pulse, high in the cycle after the offending edge and 0 otherwise.

Decomposition:
- Shared include file, guarded by `ifndef:
  - Defines default widths (DATA_W=2, DEPTH=4).
  - Defines the reset-active level constant (0).
  - Reused by the mux, this FIFO and later stages.
- One sub-module: fifo_mem_2b.
  - DEPTH x DATA_W register array.
  - Synchronous write port; registered read port driven by rd_ptr with a read enable.
  - The control logic (pointers, count, flags, errors) stays in fifo_2b_valid.

Test Plan:
1. Reset release: hold reset=0 for 2 cycles, then set 1. Required: empty=1, almost_empty=1, count=0, out_valid=0, out_data=2'b00, both errors 0.
2. Fill: push 2'b01, 2'b10, 2'b11, 2'b00 on consecutive cycles with no pop. Required: count reaches 4, full=1, almost_full asserts when count=3. A 5th push of 2'b11 sets overflow_err and count stays 4.
3. Drain order: pop 4 times. Required: out_data is 01, 10, 11, 00, each with out_valid=1 one cycle after its pop. Then empty=1. A 5th pop sets underflow_err with out_valid=0.
4. Simultaneous push and pop when full:
   - Setup: fill with 0,1,2,3.
   - Stimulus: in_valid=1 with in_data=2'b10, and pop=1.
   - Required: out_data=0, count stays 4, no overflow.
   - Three more pops return 1, 2, 3; the fourth returns 2'b10.
5. Push and pop on empty: from count=0, in_valid=1 with in_data=2'b11, and pop=1. Required: out_valid=0, underflow_err set, count=1. The next pop returns 2'b11.
6. Reset mid-stream and sticky check:
   - Push 3 words, then reset=0 for 1 cycle. Required: count=0 and errors cleared.
   - With FIFO_ERR_STICKY_EN defined: an error raised earlier persists until this reset.
   - Without the macro: the error is a 1-cycle pulse.
